pcre_nfa_engine: RTL
====================

PCRE_NFA_ENGINE -- requirements
Module: pcre_nfa_engine

Interface
REQ-001 Parameter NUM_STATES, default 8: number of one-hot NFA state registers, 2..64.
REQ-002 Parameter NUM_CLASSES, default 16: number of character-class match inputs, 1..128.
REQ-003 Parameter CLASS_SEL, default all 0: per-state class index, NUM_STATES fields of 7 bits.
REQ-004 Parameter PRED_MASK, default 0: per-state predecessor bitmap, NUM_STATES x NUM_STATES bits.
REQ-005 Parameter START_MASK, default 1: states that may be entered from the start condition.
REQ-006 Parameter ACCEPT_MASK, default MSB set: accepting states.
REQ-007 Parameter ANCHORED, default 1: 1 means start condition only at byte offset 0 (^); 0 means start at every byte.
REQ-008 Parameter OFF_W, default 16: byte offset counter width.
REQ-009 clk  input  1  sole clock; all logic on rising edge.
REQ-010 rst_n  input  1  reset, synchronous, active-low.
REQ-011 sod  input  1  start-of-data; synchronous clear of per-packet context.
REQ-012 en  input  1  byte-valid strobe; in_cls is meaningful only when en=1.
REQ-013 in_cls  input  NUM_CLASSES  one bit per class; 1 = current byte belongs to the class.
REQ-014 match  output  1  sticky match flag for the current packet.
REQ-015 match_pulse  output  1  one-cycle pulse on the first match of a packet.
REQ-016 match_offset  output  OFF_W  offset of the byte completing the first match; present only with the macro.

Function
REQ-017 Next state for state i is in_cls[CLASS_SEL[i]] AND (OR over (state AND PRED_MASK[i]) OR (START_MASK[i] AND start_ok)).
REQ-018 start_ok is (offset==0) when ANCHORED=1, and constant 1 when ANCHORED=0.
REQ-019 State registers, offset and outputs update only on cycles with en=1; with en=0 all hold.
REQ-020 The offset counter increments once per en cycle and saturates at all-ones, with no wrap.
REQ-021 Once offset saturates, start_ok stays 0 in anchored mode.
REQ-022 acc = OR over (state AND ACCEPT_MASK) is registered into match on the next en cycle, giving 2 en cycles from the final byte to match=1.
REQ-023 match stays 1 until sod or reset, and further accepts do not re-pulse.
REQ-024 match_pulse is 1 for exactly one clk cycle, the same cycle match rises 0->1.
REQ-025 sod=1 clears state, offset, match and match_offset, and ignores the in_cls byte of that cycle.
REQ-026 sod takes priority over en.
REQ-027 The next en cycle after sod is offset 0.
REQ-028 Self-loops (PRED_MASK[i][i]=1) shall work, supporting +, * and [^x]* constructs.
REQ-029 Accept on the last byte before sod is discarded, because sod clears the pipeline.

Reset
REQ-030 While rst_n=0 at a clock edge, all state bits, the offset counter, match, match_pulse and match_offset become 0.
REQ-031 rst_n has priority over sod and en.
REQ-032 Reset mid-packet discards any in-flight partial match.

Configuration
REQ-033 Macro PCRE_NFA_MATCH_OFFSET_EN defined: the offset register and match_offset port exist.
REQ-034 With the macro, match_offset is captured as offset-1 of the byte that completed the match, and holds until sod or reset.
REQ-035 Without the macro, the port and the capture register are absent, and all other behaviour is identical.

Structure
REQ-036 Package pcre_nfa_pkg holds the CLASS_SEL field width (7), the maximum state and class counts, and the function extracting a flattened per-state field.
REQ-037 Sub-module pcre_nfa_state_cell holds one state: class bit, predecessor-OR, start term and flop with en/sod/rst_n.
REQ-038 The top generates NUM_STATES cell instances plus the offset, match and capture logic.

Verification
REQ-039 Test pattern /^ab+c/: 3 states with classes a, b, c; PRED s1={s0,s1}, PRED s2={s1}; START {s0}; ACCEPT {s2}.
REQ-040 sod, then "abbbc": match=1 two en cycles after 'c', match_pulse single cycle, match_offset=4.
REQ-041 sod, then "xabc" with ANCHORED=1: match stays 0.
REQ-042 Same stream with ANCHORED=0: match=1, match_offset=3.
REQ-043 "abc" with en toggling 1,0,1,0,1: same result as contiguous, match_offset=2.
REQ-044 "abcabc": one match_pulse only, match held.
REQ-045 sod asserted on the cycle after 'c': match stays 0.
REQ-046 rst_n=0 during "ab": all outputs 0; after release, "c" alone gives no match.
REQ-047 With OFF_W=4 and ANCHORED=0, 20 bytes of 'x' then "abc": match=1, match_offset=15 (saturated).

Source files
------------

// File: rtl/pcre_nfa_pkg.sv
// Shared constants and helpers for the PCRE NFA engine.
package pcre_nfa_pkg;

    // Width of one per-state class-select field.
    localparam int unsigned CLS_SEL_W   = 7;
    localparam int unsigned MAX_STATES  = 64;
    localparam int unsigned MAX_CLASSES = 128;

    // Extract the class index for state idx from a flattened, max-width select vector.
    function automatic int unsigned class_field(
        input logic [MAX_STATES*CLS_SEL_W-1:0] flat,
        input int unsigned                     idx
    );
        logic [CLS_SEL_W-1:0] field;
        field = flat[idx*CLS_SEL_W +: CLS_SEL_W];
        return {{(32-CLS_SEL_W){1'b0}}, field};
    endfunction

endpackage

// File: rtl/pcre_nfa_state_cell.sv
// One NFA state: class gate, predecessor OR, start term and the state flop.
module pcre_nfa_state_cell #(
    parameter int unsigned           NUM_STATES = 8,
    parameter logic [NUM_STATES-1:0] PRED       = '0,
    parameter logic                  START      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sod,
    input  logic                  en,
    input  logic                  cls_bit,
    input  logic                  start_ok,
    input  logic [NUM_STATES-1:0] state_vec,
    output logic                  active
);

    logic active_d;
    logic active_q;

    // Enter when the byte is in our class and either a predecessor was active or we may start.
    always_comb begin
        active_d = cls_bit & ((|(state_vec & PRED)) | (START & start_ok));
    end

    // State flop: reset wins over sod, sod wins over en, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
        end else if (sod) begin
            active_q <= 1'b0;
        end else if (en) begin
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/pcre_nfa_engine.sv
// One-hot NFA regex matcher driven by per-byte character-class bits.
// Optional build macro PCRE_NFA_MATCH_OFFSET_EN adds the match_offset capture port.
module pcre_nfa_engine
    import pcre_nfa_pkg::*;
#(
    parameter int unsigned                          NUM_STATES  = 8,
    parameter int unsigned                          NUM_CLASSES = 16,
    parameter logic [NUM_STATES*CLS_SEL_W-1:0]      CLASS_SEL   = '0,
    parameter logic [NUM_STATES*NUM_STATES-1:0]     PRED_MASK   = '0,
    parameter logic [NUM_STATES-1:0]                START_MASK  = {{(NUM_STATES-1){1'b0}}, 1'b1},
    parameter logic [NUM_STATES-1:0]                ACCEPT_MASK = {1'b1, {(NUM_STATES-1){1'b0}}},
    parameter logic                                 ANCHORED    = 1'b1,
    parameter int unsigned                          OFF_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sod,
    input  logic                   en,
    input  logic [NUM_CLASSES-1:0] in_cls,
    output logic                   match,
    output logic                   match_pulse
`ifdef PCRE_NFA_MATCH_OFFSET_EN
    ,
    output logic [OFF_W-1:0]       match_offset
`endif
);

    localparam logic [MAX_STATES*CLS_SEL_W-1:0] CLASS_SEL_EXT =
        (MAX_STATES*CLS_SEL_W)'(CLASS_SEL);

    logic [NUM_STATES-1:0] state;
    logic [OFF_W-1:0]      offset_q;
    logic                  offset_sat;
    logic                  start_ok;
    logic                  acc;
    logic                  match_q;
    logic                  pulse_q;

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
        localparam int unsigned CLS_IDX = class_field(CLASS_SEL_EXT, i);
        logic cls_bit;

        // A class index beyond the inputs can never match.
        if (CLS_IDX < NUM_CLASSES) begin : g_cls
            assign cls_bit = in_cls[CLS_IDX];
        end else begin : g_no_cls
            assign cls_bit = 1'b0;
        end

        pcre_nfa_state_cell #(
            .NUM_STATES (NUM_STATES),
            .PRED       (PRED_MASK[i*NUM_STATES +: NUM_STATES]),
            .START      (START_MASK[i])
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .sod       (sod),
            .en        (en),
            .cls_bit   (cls_bit),
            .start_ok  (start_ok),
            .state_vec (state),
            .active    (state[i])
        );
    end

    // Start condition and accept detection from the current state vector.
    always_comb begin
        offset_sat = &offset_q;
        start_ok   = ANCHORED ? (offset_q == '0) : 1'b1;
        acc        = |(state & ACCEPT_MASK);
    end

    // Byte offset, sticky match and first-match pulse; pulse drops on any following clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= '0;
            match_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else if (sod) begin
            offset_q <= '0;
            match_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else if (en) begin
            if (!offset_sat) begin
                offset_q <= offset_q + 1'b1;
            end
            match_q <= match_q | acc;
            pulse_q <= acc & ~match_q;
        end else begin
            pulse_q <= 1'b0;
        end
    end

    assign match       = match_q;
    assign match_pulse = pulse_q;

`ifdef PCRE_NFA_MATCH_OFFSET_EN
    logic [OFF_W-1:0] prev_off_q;
    logic [OFF_W-1:0] match_off_q;

    // prev_off_q is the offset of the previous byte, i.e. offset-1, but it stays exact once the
    // counter saturates; it is latched into match_off_q when match first rises.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_off_q  <= '0;
            match_off_q <= '0;
        end else if (sod) begin
            prev_off_q  <= '0;
            match_off_q <= '0;
        end else if (en) begin
            prev_off_q <= offset_q;
            if (acc && !match_q) begin
                match_off_q <= prev_off_q;
            end
        end
    end

    assign match_offset = match_off_q;
`endif

endmodule
